encoder_scan_nbit: RTL and testbench
====================================

# encoder_scan_nbit

Sequential N-bit encoder, the inverse of the N-bit one-hot decoder. Captures a 2**N-bit request vector on a load strobe and emits the binary index of every set bit, lowest index first, one index per valid/ready handshake. A done pulse marks the end of each vector. It converts multi-hot status or request words into a stream of indices for downstream decoders and counters.

## Interface

- N, default 4: index width; request vector width is 2**N.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  2**N  request vector; sampled only on an accepted load.
- load  in  1  capture strobe; honoured only when busy=0.
- idx  out  N  index of the lowest pending set bit; meaningful only while valid=1.
- valid  out  1  idx is presented.
- ready  in  1  downstream accepts idx when valid=1 and ready=1 on a rising edge.
- busy  out  1  a vector is being served.
- done  out  1  one-cycle pulse after the last index of a vector is accepted, or after loading an all-zero vector.
- served  out  N+1  number of indices accepted since the last load (0..2**N).

## Operation

- Reset values (asynchronous, applied immediately): state=IDLE, pending=0, valid=0, busy=0, done=0, served=0. idx=0, because pending=0 drives idx=0.
- States:
  - IDLE: busy=0, valid=0. On load=1: pending<=req, served<=0.
    - If req!=0, go to SERVE.
    - If req==0, stay in IDLE and set done<=1 for exactly one cycle.
  - SERVE: busy=1, valid=1, idx=lowest set bit of pending.
    - On valid&&ready: clear bit idx in pending and set served<=served+1.
    - If that bit was the only one set, go to IDLE and set done<=1 for one cycle.
    - Otherwise stay in SERVE with the next idx.
- load while busy=1 is ignored. pending, served and the state are unaffected.
- valid never deasserts without a handshake. idx stays stable while valid=1 and ready=0.
- Simultaneous final handshake and load in the same cycle: load is ignored, because busy=1 in that cycle.
- served saturates naturally at 2**N. The N+1-bit width is required for req all ones.
- done is registered. It is low at every other time, including on reset.

## Timing

- Load accepted at edge k: valid=1, busy=1 and idx valid after edge k.
- Throughput: one index per cycle with ready held high. A vector with m set bits completes in m cycles. done is high in the cycle after the m-th handshake, with valid=0 and busy=0 in that cycle.
- A new load is accepted in the same cycle that done is high, because busy=0 then.
- An all-zero load at edge k gives done=1 after edge k. valid stays 0 throughout.
- reset_n low mid-operation: all outputs return to their reset values immediately, with no done pulse. Normal operation resumes on the first clk edge after reset_n rises.

## Structure

- Shared package encoder_pkg holds the state typedef (IDLE, SERVE) and the helper constant for vector width, 2**N.
- Sub-module lsb_index_nbit (parameter N) is purely combinational. It returns the lowest set-bit index of a 2**N vector plus a flag that is 1 when any bit is set. The top level is the FSM, the pending register, the served counter and the done register.

## Test plan

- Reset: hold reset_n=0 with load=1 and req=16'hFFFF. Expect valid=0, busy=0, done=0, served=0. After release with load=0, outputs stay idle.
- Load req=16'h8421 with ready=1 constant. Expect idx 0, 5, 10, 15 on four consecutive cycles, then done=1 for one cycle and served=4.
- Load req=16'h0000. Expect done=1 in the cycle after load, valid never high, busy never high and served=0.
- Load req=16'h0003 with ready=0 for 3 cycles, then ready=1. Expect valid held with idx=0 stable for 3 cycles, then idx 0 and 1 accepted, done pulses and served=2.
- Load req=16'hFFFF with ready=1, and pulse load with req=16'h0001 mid-stream. Expect the second load ignored, idx 0..15 in order and served=16 (5'b10000).
- Load req=16'h8421 and accept idx 0, then pulse reset_n low. Expect valid=0, busy=0, served=0 immediately and no done pulse. After release, load 16'h8000: expect idx=15, then done.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared types and width helpers for the sequential N-bit scan encoder.
package encoder_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_e;

    localparam int DEFAULT_N = 4;

    // Request vector width for a given index width.
    function automatic int vec_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/lsb_index_nbit.sv
// Combinational lowest-set-bit finder over a 2**N-bit vector.
module lsb_index_nbit
    import encoder_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic [(1<<N)-1:0] vec,
    output logic [N-1:0]      idx,
    output logic              any
);

    localparam int W = vec_width(N);

    // NOTE: idx gets a default before the loop so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = N'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/encoder_scan_nbit.sv
// Captures a 2**N request vector and streams the index of each set bit,
// lowest first, over a valid/ready handshake; pulses done at end of vector.
module encoder_scan_nbit
    import encoder_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [(1<<N)-1:0] req,
    input  logic              load,
    output logic [N-1:0]      idx,
    output logic              valid,
    input  logic              ready,
    output logic              busy,
    output logic              done,
    output logic [N:0]        served
);

    localparam int W = vec_width(N);

    state_e         state_q, state_d;
    logic [W-1:0]   pending_q, pending_d;
    logic [N:0]     served_q, served_d;
    logic           done_q, done_d;
    logic           pending_any;

    lsb_index_nbit #(.N(N)) u_lsb (
        .vec (pending_q),
        .idx (idx),
        .any (pending_any)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        served_d  = served_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    pending_d = req;
                    served_d  = '0;
                    if (req != '0) begin
                        state_d = SERVE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SERVE: begin
                if (ready) begin
                    // x & (x-1) clears exactly the lowest set bit, i.e. bit idx.
                    pending_d = pending_q & (pending_q - W'(1));
                    served_d  = served_q + (N+1)'(1);
                    if (pending_d == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            served_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            served_q  <= served_d;
            done_q    <= done_d;
        end
    end

    // SERVE is only entered with a non-empty vector, so pending_any is implied there.
    assign valid  = (state_q == SERVE) && pending_any;
    assign busy   = (state_q == SERVE);
    assign done   = done_q;
    assign served = served_q;

endmodule

// File: tb/tb_encoder_scan_nbit.sv
// Directed self-checking bench for encoder_scan_nbit with N=4.
module tb_encoder_scan_nbit;

    logic        clk;
    logic        reset_n;
    logic [15:0] req;
    logic        load;
    logic [3:0]  idx;
    logic        valid;
    logic        ready;
    logic        busy;
    logic        done;
    logic [4:0]  served;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    encoder_scan_nbit #(.N(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .load    (load),
        .idx     (idx),
        .valid   (valid),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .served  (served)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic exp_done, input logic [4:0] exp_served);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_served"}, 32'(served), 32'(exp_served));
    endtask

    task automatic check_serve(input string tag, input logic [3:0] exp_idx, input logic [4:0] exp_served);
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_idx"}, 32'(idx), 32'(exp_idx));
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_served"}, 32'(served), 32'(exp_served));
    endtask

    initial begin
        // Reset held with an active load: nothing may be captured.
        reset_n = 1'b0;
        load    = 1'b1;
        req     = 16'hFFFF;
        ready   = 1'b0;
        #1;
        check_idle("rst0", 1'b0, 5'd0);
        check("rst0_idx", 32'(idx), 32'd0);
        tick();
        tick();
        check_idle("rst1", 1'b0, 5'd0);
        reset_n = 1'b1;
        load    = 1'b0;
        tick();
        check_idle("post_rst", 1'b0, 5'd0);

        // 16'h8421 with ready held high: 0, 5, 10, 15 back to back.
        req   = 16'h8421;
        load  = 1'b1;
        ready = 1'b1;
        tick();
        load = 1'b0;
        check_serve("v8421_0", 4'd0, 5'd0);
        tick();
        check_serve("v8421_1", 4'd5, 5'd1);
        tick();
        check_serve("v8421_2", 4'd10, 5'd2);
        tick();
        check_serve("v8421_3", 4'd15, 5'd3);
        tick();
        check_idle("v8421_done", 1'b1, 5'd4);
        tick();
        check_idle("v8421_after", 1'b0, 5'd4);

        // All-zero vector: immediate done, never busy.
        req  = 16'h0000;
        load = 1'b1;
        tick();
        load = 1'b0;
        check_idle("zero_done", 1'b1, 5'd0);
        tick();
        check_idle("zero_after", 1'b0, 5'd0);

        // Backpressure: idx must stay at 0 while ready is low.
        req   = 16'h0003;
        load  = 1'b1;
        ready = 1'b0;
        tick();
        load = 1'b0;
        check_serve("bp_hold0", 4'd0, 5'd0);
        tick();
        check_serve("bp_hold1", 4'd0, 5'd0);
        tick();
        check_serve("bp_hold2", 4'd0, 5'd0);
        ready = 1'b1;
        tick();
        check_serve("bp_next", 4'd1, 5'd1);
        tick();
        check_idle("bp_done", 1'b1, 5'd2);

        // All ones with a load pulse mid-stream that must be ignored.
        req  = 16'hFFFF;
        load = 1'b1;
        tick();
        load = 1'b0;
        check_serve("ff_0", 4'd0, 5'd0);
        for (int i = 1; i < 16; i++) begin
            if (i == 3) begin
                req  = 16'h0001;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            tick();
            check_serve($sformatf("ff_%0d", i), 4'(i), 5'(i));
        end
        load = 1'b0;
        tick();
        check_idle("ff_done", 1'b1, 5'd16);
        tick();
        check_idle("ff_after", 1'b0, 5'd16);

        // Reset mid-vector: outputs clear at once with no done pulse.
        req  = 16'h8421;
        load = 1'b1;
        tick();
        load = 1'b0;
        check_serve("mid_0", 4'd0, 5'd0);
        tick();
        check_serve("mid_1", 4'd5, 5'd1);
        reset_n = 1'b0;
        #1;
        check_idle("mid_rst", 1'b0, 5'd0);
        check("mid_rst_idx", 32'(idx), 32'd0);
        tick();
        check_idle("mid_rst_hold", 1'b0, 5'd0);
        reset_n = 1'b1;
        tick();
        check_idle("mid_release", 1'b0, 5'd0);
        req  = 16'h8000;
        load = 1'b1;
        tick();
        load = 1'b0;
        check_serve("top_bit", 4'd15, 5'd0);
        tick();
        check_idle("top_done", 1'b1, 5'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
